bcd_display_ctrl: RTL and testbench

BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

---
 rtl/display_pkg.sv | 32 +++
 rtl/hex7seg.sv | 33 +++
 rtl/bcd_display_ctrl.sv | 122 ++++++++++++
 tb/tb_bcd_display_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the BCD/hex seven-segment display controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low seven-segment decoder, one per digit.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of inferred latches.
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// GPIO-driven seven-segment display: hex writes show immediately, decimal writes
// run a 32-step double-dabble conversion with leading-zero blanking and overflow flag.
module bcd_display_ctrl #(
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gpio_we,
  input  logic [31:0]                gpio_data,
  input  logic                       dec_mode,
  output logic                       stall_req,
  output logic                       busy,
  output logic                       ovf,
  output logic [NUM_DIGITS-1:0][6:0] seg
);
  import display_pkg::*;

  localparam int BCD_W = 40;
  localparam int BIN_W = 32;

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic [BCD_W-1:0]   bcd, bcd_adj, bcd_shift;
  logic [BIN_W-1:0]   bin, bin_shift;
  logic               dec_q;
  logic               accept;
  logic               dec_ovf;
  logic [NUM_DIGITS-1:0]      lz_mask;
  logic                       nonzero;
  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic [NUM_DIGITS-1:0]      blank_q;
  logic [NUM_DIGITS-1:0][6:0] raw_seg;

  assign accept = gpio_we && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gpio_we) state_next = dec_mode ? SHIFT : DONE;
      SHIFT:   if (cnt == 6'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    stall_req = gpio_we && (state != IDLE);
  end

  // One double-dabble step: correct every BCD digit >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    {bcd_shift, bin_shift} = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bcd   <= '0;
      bin   <= '0;
      dec_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      bcd   <= '0;
      bin   <= gpio_data;
      dec_q <= dec_mode;
    end else if (state == SHIFT) begin
      cnt   <= cnt + 6'd1;
      bcd   <= bcd_shift;
      bin   <= bin_shift;
    end
  end

  assign dec_ovf = |bcd[BCD_W-1:32];

  // A digit is a leading zero when it and every more significant displayed digit are zero.
  always_comb begin
    lz_mask = '0;
    nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nonzero    = nonzero | (bcd[4*i +: 4] != 4'd0);
      lz_mask[i] = !nonzero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
      blank_q <= '0;
      ovf     <= 1'b0;
    end else if (state == DONE) begin
      if (dec_q) begin
        for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= bcd[4*i +: 4];
        blank_q <= dec_ovf ? '0 : lz_mask;
        ovf     <= dec_ovf;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= bin[4*i +: 4];
        blank_q <= '0;
        ovf     <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (digit_q[i]),
      .seg    (raw_seg[i])
    );
    assign seg[i] = blank_q[i] ? SEG_BLANK : raw_seg[i];
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench: the driver pushes expected display/ovf/completion edge per write,
// a monitor pops and compares whenever busy falls (the display update edge).
module tb_bcd_display_ctrl;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            gpio_we = 1'b0;
  logic [31:0]     gpio_data = '0;
  logic            dec_mode = 1'b0;
  logic            stall_req;
  logic            busy;
  logic            ovf;
  logic [7:0][6:0] seg;

  bcd_display_ctrl #(.NUM_DIGITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_we   (gpio_we),
    .gpio_data (gpio_data),
    .dec_mode  (dec_mode),
    .stall_req (stall_req),
    .busy      (busy),
    .ovf       (ovf),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              done_edge;
    logic [7:0][6:0] seg;
    logic            ovf;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   free_at  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_busy = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0][6:0] all_zero_seg;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic on the written value.
  function automatic void model(input logic [31:0] d, input logic m,
                                output logic [7:0][6:0] s, output logic o);
    longint unsigned v, pw;
    int dig;
    o = 1'b0;
    if (!m) begin
      for (int i = 0; i < 8; i++) s[i] = seg_tab[(d >> (4 * i)) & 32'hF];
    end else begin
      v = longint'(d);
      o = (v > 64'd99999999);
      if (o) v = v % 64'd100000000;
      pw = 1;
      for (int i = 0; i < 8; i++) begin
        dig  = int'((v / pw) % 10);
        s[i] = (i == 0 || o || v >= pw) ? seg_tab[dig] : 7'h7F;
        pw   = pw * 10;
      end
    end
  endfunction

  // Drives one write from the next negedge and holds gpio_we until the model says it is taken.
  task automatic do_write(input logic [31:0] d, input logic m, output int acc);
    exp_t e;
    int   issue;
    @(negedge clk);
    gpio_we   = 1'b1;
    gpio_data = d;
    dec_mode  = m;
    issue = edge_cnt + 1;
    acc   = (issue > free_at) ? issue : free_at;
    e.done_edge = acc + (m ? 33 : 1);
    model(d, m, e.seg, e.ovf);
    q.push_back(e);
    free_at = e.done_edge + 1;
    for (int c = issue; c <= acc; c++) begin
      #1 check("stall_req", 64'(stall_req), 64'(c < acc));
      if (c < acc) @(negedge clk);
    end
    @(posedge clk);
    #1 gpio_we = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          check("unexpected_update", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("update_edge", 64'(edge_cnt), 64'(e.done_edge));
          check("seg", 64'(seg), 64'(e.seg));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    int acc;
    int t;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) all_zero_seg[i] = 7'h40;

    // Reset state, with a write strobe pending to show it is not stalled.
    repeat (2) @(posedge clk);
    gpio_we = 1'b1;
    #1;
    check("reset_seg", 64'(seg), 64'(all_zero_seg));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    gpio_we = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    free_at = 0;

    // Directed cases, issued back to back so later writes stall behind earlier ones.
    do_write(32'hDEADBEEF, 1'b0, acc);
    do_write(32'd12345678, 1'b1, acc);
    do_write(32'd100000000, 1'b1, acc);
    do_write(32'd0, 1'b1, acc);
    do_write(32'd99999999, 1'b1, acc);
    do_write(32'hFFFFFFFF, 1'b1, acc);
    do_write(32'h01234567, 1'b0, acc);
    do_write(32'h89ABCDEF, 1'b0, acc);
    do_write(32'd7, 1'b1, acc);
    do_write(32'h00000000, 1'b0, acc);

    // Randomized mix of modes and magnitudes.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0:       d = $urandom_range(0, 999);
        1:       d = $urandom_range(0, 99999999);
        default: d = $urandom;
      endcase
      do_write(d, 1'($urandom_range(0, 1)), acc);
    end

    // Overflowing result first, then abort the next conversion mid-shift.
    do_write(32'hFFFFFFFF, 1'b1, acc);
    do_write(32'd87654321, 1'b1, acc);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    q.pop_back();
    #1;
    check("abort_seg", 64'(seg), 64'(all_zero_seg));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    free_at = 0;
    do_write(32'd2024, 1'b1, acc);
    check("post_reset_accept", 64'(acc), 64'(edge_cnt));
    do_write(32'hCAFE0042, 1'b0, acc);

    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_pending", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
